// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
//   Two-requester round-robin arbiter in front of a single register-file
//   write port. Requester A is the ALU writeback, requester B the load unit.
//   A grant (x_ready) is combinational in the request cycle; the selected
//   write reaches the register file one cycle later on we/waddr/wdata.
//
// Ports
//   clk           single clock, rising edge
//   rst_n         synchronous active-low reset
//   hold          pipeline stall, suppresses all grants
//   a_valid/a_rd/a_data/a_ready   requester A handshake
//   b_valid/b_rd/b_data/b_ready   requester B handshake
//   we/waddr/wdata                registered register-file write port
//   grant_id      registered source of the current write (0 = A, 1 = B)
//   conflict_cnt  saturating count of cycles where both requested unstalled
module regfile_write_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hold,
  input  logic              a_valid,
  input  logic [ADDR_W-1:0] a_rd,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [ADDR_W-1:0] b_rd,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_ready,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [DATA_W-1:0] wdata,
  output logic              grant_id,
  output logic [7:0]        conflict_cnt
);

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    sat_inc8 = (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Round-robin pointer: 1 means B was granted last, so A wins next tie.
  logic              last;
  logic              gnt_a_p0;
  logic              gnt_b_p0;
  logic              xfer_p0;
  logic              contend_p0;
  logic [ADDR_W-1:0] sel_rd_p0;
  logic [DATA_W-1:0] sel_data_p0;

  logic              vld_p1;
  logic [ADDR_W-1:0] waddr_p1;
  logic [DATA_W-1:0] wdata_p1;
  logic              gid_p1;
  logic [7:0]        cnt_p1;

  // ---- stage p0: combinational arbitration in the request cycle ----
  always_comb begin
    gnt_a_p0    = 1'b0;
    gnt_b_p0    = 1'b0;
    sel_rd_p0   = a_rd;
    sel_data_p0 = a_data;
    if (rst_n && !hold) begin
      gnt_a_p0 = a_valid && (!b_valid || last);
      gnt_b_p0 = b_valid && (!a_valid || !last);
    end
    if (gnt_b_p0) begin
      sel_rd_p0   = b_rd;
      sel_data_p0 = b_data;
    end
  end

  assign xfer_p0    = gnt_a_p0 || gnt_b_p0;
  assign contend_p0 = a_valid && b_valid && !hold;
  assign a_ready    = gnt_a_p0;
  assign b_ready    = gnt_b_p0;

  // ---- stage p1: registered write port ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last     <= 1'b1;
      vld_p1   <= 1'b0;
      waddr_p1 <= '0;
      wdata_p1 <= '0;
      gid_p1   <= 1'b0;
      cnt_p1   <= 8'd0;
    end else begin
      if (xfer_p0) begin
        last     <= gnt_b_p0;
        // x0 is hardwired zero: the handshake completes but nothing is written.
        vld_p1   <= (sel_rd_p0 != '0);
        waddr_p1 <= sel_rd_p0;
        wdata_p1 <= sel_data_p0;
        gid_p1   <= gnt_b_p0;
      end else begin
        vld_p1   <= 1'b0;
      end
      if (contend_p0) begin
        cnt_p1 <= sat_inc8(cnt_p1);
      end
    end
  end

  assign we           = vld_p1;
  assign waddr        = waddr_p1;
  assign wdata        = wdata_p1;
  assign grant_id     = gid_p1;
  assign conflict_cnt = cnt_p1;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
module tb_regfile_write_arbiter;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  logic              clk;
  logic              rst_n;
  logic              hold;
  logic              a_valid;
  logic [ADDR_W-1:0] a_rd;
  logic [DATA_W-1:0] a_data;
  logic              a_ready;
  logic              b_valid;
  logic [ADDR_W-1:0] b_rd;
  logic [DATA_W-1:0] b_data;
  logic              b_ready;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic              grant_id;
  logic [7:0]        conflict_cnt;

  int checks = 0;
  int errors = 0;

  regfile_write_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .hold(hold),
    .a_valid(a_valid), .a_rd(a_rd), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_rd(b_rd), .b_data(b_data), .b_ready(b_ready),
    .we(we), .waddr(waddr), .wdata(wdata), .grant_id(grant_id),
    .conflict_cnt(conflict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge, then settle 1ns past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    a_valid = 1'b0; b_valid = 1'b0; hold = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; hold = 1'b0;
    a_valid = 1'b1; a_rd = 5'd7; a_data = 32'h1234_5678;
    b_valid = 1'b1; b_rd = 5'd8; b_data = 32'h8765_4321;
    #1;
    checks++;
    if (a_ready !== 1'b0 || b_ready !== 1'b0) begin
      errors++; $display("FAIL reset_ready: a=%b b=%b expected 0 0", a_ready, b_ready);
    end
    step();
    step();
    checks++;
    if (we !== 1'b0 || waddr !== '0 || wdata !== '0 || grant_id !== 1'b0 || conflict_cnt !== 8'd0) begin
      errors++;
      $display("FAIL reset_outputs: we=%b waddr=%0d wdata=%h gid=%b cnt=%0d expected all 0",
               we, waddr, wdata, grant_id, conflict_cnt);
    end
    idle_inputs();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single_a();
    a_valid = 1'b1; a_rd = 5'd5; a_data = 32'hFFFF_FFFF;
    #1;
    checks++;
    if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
      errors++; $display("FAIL single_a_ready: a=%b b=%b expected 1 0", a_ready, b_ready);
    end
    step();
    a_valid = 1'b0;
    checks++;
    if (we !== 1'b1 || waddr !== 5'd5 || wdata !== 32'hFFFF_FFFF || grant_id !== 1'b0) begin
      errors++;
      $display("FAIL single_a_write: we=%b waddr=%0d wdata=%h gid=%b expected 1 5 ffffffff 0",
               we, waddr, wdata, grant_id);
    end
    step();
    checks++;
    if (we !== 1'b0 || waddr !== 5'd5 || wdata !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL idle_hold_outputs: we=%b waddr=%0d wdata=%h expected 0 5 ffffffff",
               we, waddr, wdata);
    end
  endtask

  // Reset first so last = 1 and the sequence starts with A.
  task automatic test_contention();
    logic exp_b;
    rst_n = 1'b0; step(); rst_n = 1'b1;
    a_valid = 1'b1; a_rd = 5'd1; a_data = 32'h0000_0011;
    b_valid = 1'b1; b_rd = 5'd2; b_data = 32'h0000_0022;
    for (int i = 0; i < 4; i++) begin
      exp_b = (i % 2) == 1;
      #1;
      checks++;
      if (a_ready !== !exp_b || b_ready !== exp_b) begin
        errors++;
        $display("FAIL contention_grant[%0d]: a=%b b=%b expected %b %b", i, a_ready, b_ready, !exp_b, exp_b);
      end
      step();
      checks++;
      if (we !== 1'b1 || waddr !== (exp_b ? 5'd2 : 5'd1) || grant_id !== exp_b) begin
        errors++;
        $display("FAIL contention_write[%0d]: we=%b waddr=%0d gid=%b expected 1 %0d %b",
                 i, we, waddr, grant_id, exp_b ? 2 : 1, exp_b);
      end
    end
    idle_inputs();
    checks++;
    if (conflict_cnt !== 8'd4) begin
      errors++; $display("FAIL contention_cnt: got %0d expected 4", conflict_cnt);
    end
  endtask

  // last = 1 (B) on entry; hold must not disturb it.
  task automatic test_hold();
    hold = 1'b1; a_valid = 1'b1; b_valid = 1'b1;
    a_rd = 5'd1; b_rd = 5'd2;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if (a_ready !== 1'b0 || b_ready !== 1'b0) begin
        errors++; $display("FAIL hold_ready[%0d]: a=%b b=%b expected 0 0", i, a_ready, b_ready);
      end
      step();
      checks++;
      if (we !== 1'b0 || conflict_cnt !== 8'd4) begin
        errors++; $display("FAIL hold_state[%0d]: we=%b cnt=%0d expected 0 4", i, we, conflict_cnt);
      end
    end
    hold = 1'b0;
    #1;
    checks++;
    if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
      errors++; $display("FAIL hold_last_kept: a=%b b=%b expected 1 0", a_ready, b_ready);
    end
    step();
    idle_inputs();
    checks++;
    if (we !== 1'b1 || waddr !== 5'd1 || conflict_cnt !== 8'd5) begin
      errors++; $display("FAIL hold_release: we=%b waddr=%0d cnt=%0d expected 1 1 5", we, waddr, conflict_cnt);
    end
  endtask

  // last = 0 (A) on entry.
  task automatic test_rd_zero();
    b_valid = 1'b1; b_rd = 5'd0; b_data = 32'h0F0F_0F0F;
    #1;
    checks++;
    if (b_ready !== 1'b1 || a_ready !== 1'b0) begin
      errors++; $display("FAIL rd0_ready: a=%b b=%b expected 0 1", a_ready, b_ready);
    end
    step();
    checks++;
    if (we !== 1'b0) begin
      errors++; $display("FAIL rd0_no_write: we=%b expected 0", we);
    end
    a_valid = 1'b1; a_rd = 5'd1; a_data = 32'h0000_00A1;
    b_valid = 1'b1; b_rd = 5'd2;
    #1;
    checks++;
    if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
      errors++; $display("FAIL rd0_last_update: a=%b b=%b expected 1 0", a_ready, b_ready);
    end
    step();
    idle_inputs();
    checks++;
    if (we !== 1'b1 || waddr !== 5'd1 || wdata !== 32'h0000_00A1 || grant_id !== 1'b0 || conflict_cnt !== 8'd6) begin
      errors++;
      $display("FAIL rd0_follow_write: we=%b waddr=%0d wdata=%h gid=%b cnt=%0d expected 1 1 a1 0 6",
               we, waddr, wdata, grant_id, conflict_cnt);
    end
  endtask

  // last = 0 on entry: B wins the equal-rd tie, then A writes later with new data.
  task automatic test_same_rd();
    a_valid = 1'b1; a_rd = 5'd3; a_data = 32'h0000_0AAA;
    b_valid = 1'b1; b_rd = 5'd3; b_data = 32'h0000_0BBB;
    #1;
    checks++;
    if (b_ready !== 1'b1 || a_ready !== 1'b0) begin
      errors++; $display("FAIL same_rd_grant: a=%b b=%b expected 0 1", a_ready, b_ready);
    end
    step();
    checks++;
    if (we !== 1'b1 || waddr !== 5'd3 || wdata !== 32'h0000_0BBB || grant_id !== 1'b1) begin
      errors++;
      $display("FAIL same_rd_first: we=%b waddr=%0d wdata=%h gid=%b expected 1 3 bbb 1", we, waddr, wdata, grant_id);
    end
    b_valid = 1'b0; a_data = 32'h0000_0CCC;
    step();
    idle_inputs();
    checks++;
    if (we !== 1'b1 || waddr !== 5'd3 || wdata !== 32'h0000_0CCC || grant_id !== 1'b0) begin
      errors++;
      $display("FAIL same_rd_second: we=%b waddr=%0d wdata=%h gid=%b expected 1 3 ccc 0", we, waddr, wdata, grant_id);
    end
  endtask

  task automatic test_saturate_and_reset();
    int both = 0;
    a_valid = 1'b1; a_rd = 5'd9; a_data = 32'h9999_9999;
    b_valid = 1'b1; b_rd = 5'd10; b_data = 32'hAAAA_AAAA;
    for (int i = 0; i < 300; i++) begin
      #1;
      if (a_ready === 1'b1 && b_ready === 1'b1) both++;
      step();
    end
    checks++;
    if (both != 0) begin
      errors++; $display("FAIL exclusive_ready: both-ready cycles=%0d expected 0", both);
    end
    checks++;
    if (conflict_cnt !== 8'd255) begin
      errors++; $display("FAIL saturate: cnt=%0d expected 255", conflict_cnt);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (a_ready !== 1'b0 || b_ready !== 1'b0) begin
      errors++; $display("FAIL midreq_ready: a=%b b=%b expected 0 0", a_ready, b_ready);
    end
    step();
    checks++;
    if (we !== 1'b0 || waddr !== '0 || wdata !== '0 || grant_id !== 1'b0 || conflict_cnt !== 8'd0) begin
      errors++;
      $display("FAIL midreq_outputs: we=%b waddr=%0d wdata=%h gid=%b cnt=%0d expected all 0",
               we, waddr, wdata, grant_id, conflict_cnt);
    end
    rst_n = 1'b1;
    idle_inputs();
    step();
    checks++;
    if (we !== 1'b0) begin
      errors++; $display("FAIL midreq_no_pulse: we=%b expected 0", we);
    end
  endtask

  initial begin
    rst_n = 1'b0; hold = 1'b0;
    a_valid = 1'b0; a_rd = '0; a_data = '0;
    b_valid = 1'b0; b_rd = '0; b_data = '0;
    test_reset();
    test_single_a();
    test_contention();
    test_hold();
    test_rd_zero();
    test_same_rd();
    test_saturate_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
- REQ-001 The block SHALL have parameter DATA_W, default 32, meaning the write-data width.
- REQ-002 The block SHALL have parameter ADDR_W, default 5, meaning the register-address width (32 registers).
- REQ-003 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
- REQ-004 The block SHALL have port rst_n, input, 1, the reset; synchronous and active-low.
- REQ-005 The block SHALL have port hold, input, 1, the pipeline stall; when 1, no grant is issued.
- REQ-006 The block SHALL have port a_valid, input, 1, requester A (ALU writeback) has a write pending.
- REQ-007 The block SHALL have port a_rd, input, ADDR_W, requester A destination register.
- REQ-008 The block SHALL have port a_data, input, DATA_W, requester A write data.
- REQ-009 The block SHALL have port a_ready, output, 1, requester A is granted this cycle (combinational).
- REQ-010 The block SHALL have ports b_valid, b_rd, b_data and b_ready, requester B (load unit), identical in direction and width to the A ports.
- REQ-011 The block SHALL have port we, output, 1, the registered write enable to the register file.
- REQ-012 The block SHALL have port waddr, output, ADDR_W, the registered write address.
- REQ-013 The block SHALL have port wdata, output, DATA_W, the registered write data.
- REQ-014 The block SHALL have port grant_id, output, 1, the registered requester of the current write (0 = A, 1 = B).
- REQ-015 The block SHALL have port conflict_cnt, output, 8, a saturating count of contention cycles.

Function
- REQ-016 A transfer SHALL complete in any cycle where x_valid and x_ready are both 1; at most one of a_ready or b_ready SHALL be 1 in any cycle.
- REQ-017 x_ready SHALL be 0 whenever hold = 1, rst_n = 0 or x_valid = 0.
- REQ-018 The block SHALL keep a 1-bit round-robin pointer last (0 = A last granted, 1 = B last granted).
- REQ-019 With exactly one requester valid and hold = 0, that requester SHALL be granted regardless of last.
- REQ-020 With both requesters valid and hold = 0, the requester not equal to last SHALL be granted, and the other SHALL be held off (ready = 0) and SHALL retry.
- REQ-021 last SHALL update to the granted requester on every completed transfer; it SHALL be unchanged in cycles with no transfer.
- REQ-022 Latency SHALL be 1 cycle: a transfer in cycle N SHALL produce we = 1, waddr = rd, wdata = data and grant_id = requester in cycle N+1.
- REQ-023 In cycles following no transfer, we SHALL be 0 and waddr, wdata and grant_id SHALL hold their previous values.
- REQ-024 A transfer with rd = 0 SHALL complete the handshake and update last, but SHALL produce we = 0 (x0 is never written).
- REQ-025 When both requesters are valid with equal rd, only one SHALL be granted per REQ-020; the loser SHALL be written in a later cycle, giving last-writer ordering by grant.
- REQ-026 conflict_cnt SHALL increment by 1 in each cycle with a_valid = b_valid = 1 and hold = 0, and SHALL saturate at 255.
- REQ-027 Requester data and rd SHALL be sampled only on the handshake cycle; changes while not granted SHALL have no effect.

Reset
- REQ-028 While rst_n = 0 at a rising edge, the block SHALL set we = 0, waddr = 0, wdata = 0, grant_id = 0, conflict_cnt = 0 and last = 1, so that A wins the first contention.
- REQ-029 A request in progress when reset is asserted SHALL be dropped: no we pulse SHALL result from it, and ready SHALL be 0 throughout reset.

Verification
- REQ-030 Scenario: reset, then a_valid = 1, a_rd = 5, a_data = 0xFFFFFFFF for one cycle -> a_ready = 1 that cycle; next cycle we = 1, waddr = 5, wdata = 0xFFFFFFFF, grant_id = 0.
- REQ-031 Scenario: both valid for 4 cycles (a_rd = 1, b_rd = 2) -> grants alternate A, B, A, B; conflict_cnt = 4.
- REQ-032 Scenario: hold = 1 with both valid for 2 cycles -> both ready = 0, we = 0 and last unchanged; conflict_cnt unchanged.
- REQ-033 Scenario: b_valid = 1, b_rd = 0, b_data = 0x0F0F0F0F -> b_ready = 1; next cycle we = 0; then both valid -> A granted.
- REQ-034 Scenario: both valid for 300 cycles -> conflict_cnt = 255; then rst_n = 0 for one cycle mid-request -> all outputs 0, no we pulse.
